// File: rtl/img_mem_mp_clr_if.sv
// Bus bundle for the multi-read-port image buffer: clear control, NUM_RD read ports, one write port.
// Signal suffixes are from the memory's point of view (slave modport).
interface img_mem_mp_clr_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19,
  parameter int NUM_RD = 4
);
  logic                       clr_req_i;
  logic                       busy_o;
  logic                       clr_done_o;
  logic [NUM_RD-1:0]          re_i;
  logic [NUM_RD*ADDR_W-1:0]   raddr_i;
  logic [NUM_RD*DATA_W-1:0]   rdata_o;
  logic [NUM_RD-1:0]          rvalid_o;
  logic                       we_i;
  logic [ADDR_W-1:0]          waddr_i;
  logic [DATA_W-1:0]          wdata_i;
  logic                       wready_o;

  modport master (
    output clr_req_i, re_i, raddr_i, we_i, waddr_i, wdata_i,
    input  busy_o, clr_done_o, rdata_o, rvalid_o, wready_o
  );

  modport slave (
    input  clr_req_i, re_i, raddr_i, we_i, waddr_i, wdata_i,
    output busy_o, clr_done_o, rdata_o, rvalid_o, wready_o
  );
endinterface

// File: rtl/img_mem_mp_clr.sv
// Image buffer with NUM_RD read ports, write-first bypass and a sequential clear engine.
// Define IMG_MEM_OUTREG_EN to add a second output register stage (read latency 2 instead of 1).
//
// state    | meaning
// ST_IDLE  | normal operation, reads and writes accepted
// ST_CLEAR | sweeping CLEAR_VAL over every word, one per cycle
module img_mem_mp_clr #(
  parameter int              DATA_W       = 8,
  parameter int              ADDR_W       = 19,
  parameter int              NUM_RD       = 4,
  parameter logic [DATA_W-1:0] CLEAR_VAL  = '0,
  parameter bit              CLEAR_ON_RST = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  img_mem_mp_clr_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  localparam state_t ST_RST = CLEAR_ON_RST ? ST_CLEAR : ST_IDLE;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic                clr_done_q, clr_done_d;
  logic                busy;
  logic                wr_acc;
  logic [NUM_RD-1:0]   rd_acc;
  logic [DATA_W-1:0]   rd_word [NUM_RD];
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [NUM_RD*DATA_W-1:0] rdata_q;
  logic [NUM_RD-1:0]   rvalid_q;

  assign busy   = (state_q == ST_CLEAR);
  assign wr_acc = bus.we_i && !busy;
  assign rd_acc = bus.re_i & {NUM_RD{~busy}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RST;
      clr_ptr_q  <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      clr_done_q <= clr_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    clr_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_req_i) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
        end
      end
      ST_CLEAR: begin
        // pointer wraps to 0 naturally after the last word
        clr_ptr_d = clr_ptr_q + ADDR_W'(1);
        if (clr_ptr_q == '1) begin
          state_d    = ST_IDLE;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // single physical write port shared by the clear engine and the loader
  always_ff @(posedge clk) begin
    if (busy)        mem[clr_ptr_q]   <= CLEAR_VAL;
    else if (wr_acc) mem[bus.waddr_i] <= bus.wdata_i;
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      if (wr_acc && (bus.waddr_i == bus.raddr_i[i*ADDR_W +: ADDR_W]))
        rd_word[i] = bus.wdata_i;
      else
        rd_word[i] = mem[bus.raddr_i[i*ADDR_W +: ADDR_W]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      rvalid_q <= rd_acc;
      for (int i = 0; i < NUM_RD; i++)
        if (rd_acc[i]) rdata_q[i*DATA_W +: DATA_W] <= rd_word[i];
    end
  end

`ifdef IMG_MEM_OUTREG_EN
  logic [NUM_RD*DATA_W-1:0] rdata2_q;
  logic [NUM_RD-1:0]        rvalid2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata2_q  <= '0;
      rvalid2_q <= '0;
    end else begin
      rvalid2_q <= rvalid_q;
      for (int i = 0; i < NUM_RD; i++)
        if (rvalid_q[i]) rdata2_q[i*DATA_W +: DATA_W] <= rdata_q[i*DATA_W +: DATA_W];
    end
  end

  assign bus.rdata_o  = rdata2_q;
  assign bus.rvalid_o = rvalid2_q;
`else
  assign bus.rdata_o  = rdata_q;
  assign bus.rvalid_o = rvalid_q;
`endif

  assign bus.busy_o     = busy;
  assign bus.wready_o   = ~busy;
  assign bus.clr_done_o = clr_done_q;

endmodule
